// File: rtl/rc4_search_pkg.sv
// rc4_search_pkg: shared FSM states and plaintext character bounds for the key search engine
package rc4_search_pkg;
  typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, CHECK, NEXT_KEY, FOUND, FAIL} state_t;
  localparam logic [7:0] CH_SPACE = 8'd32;
  localparam logic [7:0] CH_LO = 8'd97;
  localparam logic [7:0] CH_HI = 8'd122;
endpackage

// File: rtl/plaintext_checker.sv
// plaintext_checker: flags a decrypted byte that is a space or a lowercase letter
module plaintext_checker
  import rc4_search_pkg::*;
(
  input  logic [7:0] p,
  output logic       valid
);
  assign valid = (p == CH_SPACE) || (p >= CH_LO && p <= CH_HI);
endmodule

// File: rtl/key_search_engine.sv
// key_search_engine: brute-force RC4 key search against a ciphertext ROM using an external S-box RAM
module key_search_engine
  import rc4_search_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN = 32,
  parameter int KEY_STEP = 1,
  parameter logic [8*KEY_BYTES-1:0] KEY_LIMIT = (8*KEY_BYTES)'(24'h3FFFFF),
  localparam int KW = 8*KEY_BYTES,
  localparam int AW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [KW-1:0] start_key,
  output logic          busy,
  output logic          found,
  output logic          fail,
  output logic [KW-1:0] secret_key,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data,
  output logic          s_wren,
  input  logic [7:0]    s_q,
  output logic [AW-1:0] e_address,
  input  logic [7:0]    e_q,
  output logic [AW-1:0] d_address,
  output logic [7:0]    d_data,
  output logic          d_wren
);
  state_t        state;
  logic [3:0]    ph;
  logic [7:0]    i, j, si, sj, jn, p;
  logic [AW-1:0] k;
  logic [KW-1:0] key_rot;
  logic [KW:0]   nk;
  logic          ok, p_ok;
  // key_rot keeps the current key byte in its top 8 bits; PRGA adds no key term
  assign jn = j + s_q + (state == KSA ? key_rot[KW-1 -: 8] : 8'd0);
  assign p  = e_q ^ s_q;
  assign nk = {1'b0, secret_key} + (KW+1)'(KEY_STEP);
  plaintext_checker u_chk (.p(p), .valid(p_ok));
  // every RAM/ROM read waits two cycles after its address is registered (phases 2, 4, 8)
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ph <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      si <= '0;
      sj <= '0;
      ok <= 1'b0;
      key_rot <= '0;
      busy <= 1'b0;
      found <= 1'b0;
      fail <= 1'b0;
      secret_key <= '0;
      s_address <= '0;
      s_data <= '0;
      s_wren <= 1'b0;
      e_address <= '0;
      d_address <= '0;
      d_data <= '0;
      d_wren <= 1'b0;
    end else if (!stop) begin
      s_wren <= 1'b0;
      d_wren <= 1'b0;
      case (state)
        IDLE, FOUND, FAIL: if (start) begin
          state <= INIT;
          secret_key <= start_key;
          busy <= 1'b1;
          found <= 1'b0;
          fail <= 1'b0;
          i <= '0;
        end
        INIT: begin
          s_address <= i;
          s_data <= i;
          s_wren <= 1'b1;
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            state <= KSA;
            ph <= 4'd1;
            j <= '0;
            key_rot <= secret_key;
          end
        end
        KSA, PRGA: case (ph)
          4'd0: begin
            i <= i + 8'd1;
            s_address <= i + 8'd1;
            ph <= 4'd2;
          end
          4'd1: begin
            s_address <= i;
            ph <= 4'd2;
          end
          4'd3: begin
            si <= s_q;
            j <= jn;
            s_address <= jn;
            ph <= 4'd4;
          end
          4'd5: begin
            sj <= s_q;
            s_data <= si;
            s_wren <= 1'b1;
            ph <= 4'd6;
          end
          4'd6: begin
            s_address <= i;
            s_data <= sj;
            s_wren <= 1'b1;
            if (state == PRGA) ph <= 4'd7;
            else begin
              key_rot <= (key_rot << 8) | (key_rot >> (KW-8));
              i <= i + 8'd1;
              ph <= i == 8'hFF ? 4'd0 : 4'd1;
              if (i == 8'hFF) begin
                state <= PRGA;
                j <= '0;
                k <= '0;
              end
            end
          end
          4'd7: begin
            s_address <= si + sj;
            e_address <= k;
            ph <= 4'd8;
          end
          4'd9: begin
            ok <= p_ok;
            d_wren <= p_ok;
            if (p_ok) begin
              d_address <= k;
              d_data <= p;
            end
            state <= CHECK;
          end
          default: ph <= ph + 4'd1;
        endcase
        CHECK: begin
          if (!ok) state <= NEXT_KEY;
          else if (k == AW'(MSG_LEN-1)) begin
            state <= FOUND;
            found <= 1'b1;
            busy <= 1'b0;
          end else begin
            k <= k + 1'b1;
            ph <= 4'd0;
            state <= PRGA;
          end
        end
        NEXT_KEY: begin
          if (nk > {1'b0, KEY_LIMIT}) begin
            state <= FAIL;
            fail <= 1'b1;
            busy <= 1'b0;
          end else begin
            secret_key <= nk[KW-1:0];
            state <= INIT;
            i <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_search_engine.sv
// tb_key_search_engine: randomized scoreboard bench with a brute-force RC4 reference search
module tb_key_search_engine;
  localparam int ML = 8;
  localparam int STEP = 2;
  localparam logic [23:0] LIM = 24'h5A3C11;
  typedef logic [7:0] msg_t [ML];
  typedef struct packed {logic [2:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic f; logic [23:0] key;} res_t;

  logic CLOCK_50 = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [23:0] start_key = '0;
  logic busy, found, fail, s_wren, d_wren;
  logic [23:0] secret_key;
  logic [7:0] s_address, s_data, s_q, e_q, d_data;
  logic [2:0] e_address, d_address;
  logic [7:0] sram [256];
  msg_t rom;
  wr_t wr_q[$];
  res_t res_q[$];
  int checks = 0, errors = 0;
  logic dw_p = 1'b0, dn_p = 1'b0;
  logic [58:0] outs;

  key_search_engine #(.KEY_BYTES(3), .MSG_LEN(ML), .KEY_STEP(STEP), .KEY_LIMIT(LIM)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop), .start_key(start_key),
    .busy(busy), .found(found), .fail(fail), .secret_key(secret_key),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .e_address(e_address), .e_q(e_q),
    .d_address(d_address), .d_data(d_data), .d_wren(d_wren)
  );

  assign outs = {busy, found, fail, secret_key, s_address, s_data, s_wren, e_address, d_address, d_data, d_wren};

  always #10 CLOCK_50 = ~CLOCK_50;

  // synchronous-read memories: q registers the addressed word one edge after the address is seen
  always @(posedge CLOCK_50) begin
    s_q <= sram[s_address];
    e_q <= rom[e_address];
    if (s_wren) sram[s_address] <= s_data;
  end

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endfunction

  function automatic bit is_text(logic [7:0] c);
    return c == 8'd32 || (c >= 8'd97 && c <= 8'd122);
  endfunction

  // textbook RC4: key bytes taken MSB first, keystream XORed onto the message
  function automatic void xcrypt(input logic [23:0] key, input msg_t din, output msg_t dout);
    logic [7:0] s [256];
    logic [7:0] a, b, t;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    b = 0;
    for (int n = 0; n < 256; n++) begin
      b = b + s[n] + key[23 - 8*(n % 3) -: 8];
      t = s[n]; s[n] = s[b]; s[b] = t;
    end
    a = 0; b = 0;
    for (int n = 0; n < ML; n++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      dout[n] = din[n] ^ s[8'(s[a] + s[b])];
    end
  endfunction

  // expected behaviour: try keys from sk upward by STEP; each accepted byte is written until a reject
  task automatic predict(input logic [23:0] sk);
    msg_t pt;
    logic [24:0] key;
    int n;
    key = {1'b0, sk};
    for (int g = 0; g < 64; g++) begin
      xcrypt(key[23:0], rom, pt);
      n = 0;
      while (n < ML && is_text(pt[n])) begin
        wr_q.push_back('{a: 3'(n), d: pt[n]});
        n++;
      end
      if (n == ML) begin
        res_q.push_back('{f: 1'b1, key: key[23:0]});
        return;
      end
      if (key + 25'(STEP) > {1'b0, LIM}) begin
        res_q.push_back('{f: 1'b0, key: key[23:0]});
        return;
      end
      key = key + 25'(STEP);
    end
  endtask

  task automatic load_cipher(input logic [23:0] key);
    msg_t pt, ct;
    int r;
    for (int n = 0; n < ML; n++) begin
      r = $urandom_range(0, 26);
      pt[n] = r == 26 ? 8'd32 : 8'(97 + r);
    end
    xcrypt(key, pt, ct);
    for (int n = 0; n < ML; n++) rom[n] = ct[n];
  endtask

  task automatic do_run(input logic [23:0] sk, output int cyc);
    predict(sk);
    @(negedge CLOCK_50);
    start_key = sk;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    cyc = 1;
    while (!(found || fail) && cyc < 20000) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    @(negedge CLOCK_50);
    chk("result_seen", res_q.size(), 0);
    res_q.delete();
    wr_q.delete();
  endtask

  // monitor: pop one expected write per d_wren pulse and one expected result per completion
  always @(negedge CLOCK_50) begin
    wr_t w;
    res_t r;
    if (reset) begin
      dw_p <= 1'b0;
      dn_p <= 1'b0;
    end else begin
      if (d_wren && !dw_p) begin
        chk("d_write_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("d_address", d_address, w.a);
          chk("d_data", d_data, w.d);
        end
      end
      if ((found || fail) && !dn_p) begin
        chk("result_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          chk("found", found, r.f);
          chk("fail", fail, !r.f);
          chk("secret_key", secret_key, r.key);
          chk("busy_done", busy, 0);
          chk("writes_left", wr_q.size(), 0);
        end
      end
      dw_p <= d_wren;
      dn_p <= found | fail;
    end
  end

  initial begin
    int ca, cb, chg;
    logic [23:0] key;
    logic [58:0] snap;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_outputs", outs, 0);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("idle_without_start", busy, 0);

    for (int t = 0; t < 3; t++) begin
      key = LIM - 24'(2 * $urandom_range(0, 4));
      load_cipher(key);
      do_run(key - 24'(2 * $urandom_range(0, 1)), ca);
    end
    load_cipher(LIM);
    do_run(LIM, ca);
    load_cipher(LIM - 24'd1);
    do_run(LIM - 24'd4, ca);
    load_cipher(LIM + 24'd2);
    do_run(LIM - 24'd2, ca);

    key = LIM - 24'(2 * $urandom_range(1, 4));
    load_cipher(key);
    do_run(key, ca);
    chg = 0;
    fork
      do_run(key, cb);
      begin
        repeat (600) @(negedge CLOCK_50);
        stop = 1'b1;
        snap = outs;
        repeat (100) begin
          @(negedge CLOCK_50);
          if (outs !== snap) chg++;
        end
        stop = 1'b0;
      end
    join
    chk("stop_hold", chg, 0);
    chk("stop_offset", cb - ca, 100);

    @(negedge CLOCK_50);
    stop = 1'b1;
    start = 1'b1;
    start_key = LIM - 24'd8;
    @(negedge CLOCK_50);
    start = 1'b0;
    stop = 1'b0;
    @(negedge CLOCK_50);
    chk("stop_beats_start_busy", busy, 0);
    chk("stop_beats_start_found", found, 1);
    chk("stop_beats_start_key", secret_key, key);

    key = LIM - 24'(2 * $urandom_range(1, 4));
    load_cipher(key);
    fork
      do_run(key, ca);
      begin
        repeat (300) @(negedge CLOCK_50);
        start_key = key - 24'd6;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
      end
    join

    key = LIM - 24'(2 * $urandom_range(0, 4));
    load_cipher(key);
    predict(key);
    @(negedge CLOCK_50);
    start_key = key;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    for (int c = 0; c < 5000 && !d_wren; c++) @(negedge CLOCK_50);
    chk("reached_prga", d_wren, 1);
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    chk("reset_mid_prga", outs, 0);
    @(negedge CLOCK_50);
    chk("reset_held", outs, 0);
    reset = 1'b0;
    wr_q.delete();
    res_q.delete();
    do_run(key, ca);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
